udp_tx_framer: RTL
==================

# udp_tx_framer

Transmit-side UDP stage of the UDP/IPv4 stack. It accepts a `udp_tx_type` request (header fields plus a byte stream from the user) and converts it into an `ipv4_tx_type` request for the IPv4 transmitter directly downstream. It prepends the 8-byte UDP header, sets protocol 17, and reports status on `udp_tx_result` using the `UDPTX_RESULT_*` codes. Every user byte passes through with backpressure from the IP layer.

## Interface
- `UDP_PROTOCOL`, 8'h11, value driven on `ip_tx_protocol`
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `udp_tx_start`  in  1  request strobe; a rising edge (high now, low last cycle) in IDLE starts a frame
- `udp_tx_dst_ip_addr` / `udp_tx_dst_port` / `udp_tx_src_port` / `udp_tx_data_length` / `udp_tx_checksum`  in  32/16/16/16/16  header fields; sampled on the start cycle
- `udp_tx_data_out_valid` / `udp_tx_data_out_last` / `udp_tx_data_out`  in  1/1/8  user payload stream
- `udp_tx_data_out_ready`  out  1  user byte accepted when `valid && ready`
- `udp_tx_result`  out  2  `UDPTX_RESULT_NONE`/`SENDING`/`ERR`/`SENT`
- `ip_tx_start`  out  1  IP request active
- `ip_tx_protocol` / `ip_tx_data_length` / `ip_tx_dst_ip_addr`  out  8/16/32  IPv4 header fields
- `ip_tx_data_out_valid` / `ip_tx_data_out_last` / `ip_tx_data_out`  out  1/1/8  stream to IP layer
- `ip_tx_data_out_ready`  in  1  IP layer accepts a byte
- `ip_tx_result`  in  2  `IPTX_RESULT_*` from the IP layer

## Operation
- **States:** IDLE, WAIT_IP, SEND_HDR, SEND_DATA.
- **IDLE:**
  - On a start edge, latch all header fields, set result to SENDING and clear the byte counter.
  - If `udp_tx_data_length > 65527`, go to IDLE with result ERR and never assert `ip_tx_start`.
  - Otherwise, if `ip_tx_result == IPTX_RESULT_SENDING`, go to WAIT_IP; else go to SEND_HDR.
- **WAIT_IP:** stay until `ip_tx_result != SENDING`, then go to SEND_HDR.
- **SEND_HDR:**
  - `ip_tx_start=1` and `ip_tx_data_out_valid=1`.
  - Bytes 0..7, big-endian: src_port hi, src_port lo, dst_port hi, dst_port lo, length hi, length lo, checksum hi, checksum lo. Length is `data_length+8`.
  - The counter advances only when `ip_tx_data_out_ready` is high.
  - After byte 7 transfers: go to SEND_DATA, or finish if `data_length==0`. In that case byte 7 carries `last`.
- **SEND_DATA:** combinational pass-through.
  - `ip_tx_data_out = udp_tx_data_out`.
  - `ip_tx_data_out_valid = udp_tx_data_out_valid`.
  - `udp_tx_data_out_ready = ip_tx_data_out_ready`.
  - The counter advances on each transfer.
  - `ip_tx_data_out_last` is generated internally: it is 1 on the byte where `count == data_length-1`.
- **Finish:** on the transfer of the last byte, go to IDLE, deassert `ip_tx_start`, and set result SENT. If a mismatch flag is set, set result ERR instead.
- **Mismatch flag:** sticky. It is set if user `last` is high on a transferred byte other than the final one, or low on the final one. The frame still completes at exactly `data_length` bytes.
- **Abort:** `ip_tx_result == IPTX_RESULT_ERR` in SEND_HDR or SEND_DATA sends the block to IDLE with result ERR, all outputs low.
- **Result hold:** the result holds until the next accepted start.
- **Constant outputs:**
  - `ip_tx_protocol = UDP_PROTOCOL`.
  - `ip_tx_dst_ip_addr` = latched address.
  - `ip_tx_data_length = data_length + 8`, 16-bit, no wrap possible after the range check.
- **Ready outside SEND_DATA:** `udp_tx_data_out_ready = 0`.

## Timing
- **Reset:**
  - State IDLE, counter 0, result NONE.
  - `ip_tx_start`, `ip_tx_data_out_valid`, `ip_tx_data_out_last`, `udp_tx_data_out_ready` = 0.
  - `ip_tx_data_out`, `ip_tx_data_length`, `ip_tx_dst_ip_addr` = 0.
- **Latency:** start edge at cycle N gives `ip_tx_start`, valid and header byte 0 at cycle N+1 when the IP layer is not SENDING. Result = SENDING from N+1.
- **Minimum frame:** 8+L transfer cycles, with zero added latency per payload byte.
- **Completion:** final transfer at cycle M gives result SENT/ERR and `ip_tx_start=0` at M+1. A new start edge is accepted from M+1.
- **Back-to-back:** a start edge during a frame is ignored, not queued.
- **Reset mid-frame:** reset has priority. It returns to the reset state next cycle, with no further bytes emitted.

## Test plan
- **Basic frame:** src 0x1234, dst 0x0050, L=4, checksum 0, ready always 1 -> bytes 12 34 00 50 00 0C 00 00 then payload. `last` on payload byte 4, `ip_tx_data_length=12`, result SENT one cycle after.
- **Backpressure:** L=3, `ip_tx_data_out_ready` toggling 1,0,1,0 -> header/payload order intact, no duplicates or drops, `udp_tx_data_out_ready` mirrors IP ready in SEND_DATA.
- **Zero length and oversize:** L=0 -> 8 header bytes, `last` on byte 7, length 8. Then L=65528 -> result ERR, `ip_tx_start` never asserted.
- **Busy IP layer:** start while `ip_tx_result=SENDING` for 5 cycles -> stays in WAIT_IP, header begins the cycle after `ip_tx_result` drops.
- **Last mismatch:** L=5 with user `last` on byte 3 -> 5 payload bytes emitted, `ip last` on byte 5, result ERR.
- **IP error / reset:** `ip_tx_result=ERR` at header byte 4 -> IDLE, result ERR. Then `reset` mid-payload -> outputs 0, result NONE next cycle.

Source files
------------

// File: rtl/udp_tx_framer.sv
// ============================================================================
// Module   : udp_tx_framer
// Brief    : Transmit-side UDP stage: prepends the 8-byte UDP header and
//            forwards the user payload to the IPv4 transmitter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module udp_tx_framer #(
    parameter logic [7:0] UDP_PROTOCOL = 8'h11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        udp_tx_start,
    input  logic [31:0] udp_tx_dst_ip_addr,
    input  logic [15:0] udp_tx_dst_port,
    input  logic [15:0] udp_tx_src_port,
    input  logic [15:0] udp_tx_data_length,
    input  logic [15:0] udp_tx_checksum,
    input  logic        udp_tx_data_out_valid,
    input  logic        udp_tx_data_out_last,
    input  logic [7:0]  udp_tx_data_out,
    output logic        udp_tx_data_out_ready,
    output logic [1:0]  udp_tx_result,
    output logic        ip_tx_start,
    output logic [7:0]  ip_tx_protocol,
    output logic [15:0] ip_tx_data_length,
    output logic [31:0] ip_tx_dst_ip_addr,
    output logic        ip_tx_data_out_valid,
    output logic        ip_tx_data_out_last,
    output logic [7:0]  ip_tx_data_out,
    input  logic        ip_tx_data_out_ready,
    input  logic [1:0]  ip_tx_result
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_IP   = 2'd1;
    localparam logic [1:0] S_SEND_HDR  = 2'd2;
    localparam logic [1:0] S_SEND_DATA = 2'd3;

    localparam logic [1:0] UDPTX_RESULT_NONE    = 2'd0;
    localparam logic [1:0] UDPTX_RESULT_SENDING = 2'd1;
    localparam logic [1:0] UDPTX_RESULT_ERR     = 2'd2;
    localparam logic [1:0] UDPTX_RESULT_SENT    = 2'd3;

    localparam logic [1:0] IPTX_RESULT_SENDING  = 2'd1;
    localparam logic [1:0] IPTX_RESULT_ERR      = 2'd2;

    localparam logic [15:0] MAX_DATA_LENGTH     = 16'd65527;

    logic [1:0]  r_state;
    logic [15:0] r_count;
    logic [1:0]  r_result;
    logic        r_start_d;
    logic        r_mismatch;
    logic [31:0] r_dst_ip;
    logic [15:0] r_dst_port;
    logic [15:0] r_src_port;
    logic [15:0] r_len;
    logic [15:0] r_ip_len;
    logic [15:0] r_cksum;

    logic        w_start_edge;
    logic        w_ip_start;
    logic        w_valid;
    logic        w_last;
    logic [7:0]  w_data;
    logic        w_uready;
    logic        w_xfer;
    logic        w_hdr_done;
    logic        w_bad_last;
    logic [7:0]  w_hdr_byte;

    assign w_start_edge = udp_tx_start && !r_start_d;
    assign w_hdr_done   = (r_count[2:0] == 3'd7);

    always_comb begin
        w_hdr_byte = 8'd0;
        case (r_count[2:0])
            3'd0:    w_hdr_byte = r_src_port[15:8];
            3'd1:    w_hdr_byte = r_src_port[7:0];
            3'd2:    w_hdr_byte = r_dst_port[15:8];
            3'd3:    w_hdr_byte = r_dst_port[7:0];
            3'd4:    w_hdr_byte = r_ip_len[15:8];
            3'd5:    w_hdr_byte = r_ip_len[7:0];
            3'd6:    w_hdr_byte = r_cksum[15:8];
            default: w_hdr_byte = r_cksum[7:0];
        endcase
    end

    // Header bytes come from the latched fields; payload is a straight pass-through.
    always_comb begin
        w_ip_start = 1'b0;
        w_valid    = 1'b0;
        w_last     = 1'b0;
        w_data     = 8'd0;
        w_uready   = 1'b0;
        case (r_state)
            S_SEND_HDR: begin
                w_ip_start = 1'b1;
                w_valid    = 1'b1;
                w_data     = w_hdr_byte;
                w_last     = w_hdr_done && (r_len == 16'd0);
            end
            S_SEND_DATA: begin
                w_ip_start = 1'b1;
                w_valid    = udp_tx_data_out_valid;
                w_data     = udp_tx_data_out;
                w_uready   = ip_tx_data_out_ready;
                w_last     = (r_count == (r_len - 16'd1));
            end
            default: begin
                w_ip_start = 1'b0;
            end
        endcase
    end

    assign w_xfer     = w_valid && ip_tx_data_out_ready;
    assign w_bad_last = (udp_tx_data_out_last != w_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= 16'd0;
            r_result   <= UDPTX_RESULT_NONE;
            r_start_d  <= 1'b0;
            r_mismatch <= 1'b0;
            r_dst_ip   <= 32'd0;
            r_dst_port <= 16'd0;
            r_src_port <= 16'd0;
            r_len      <= 16'd0;
            r_ip_len   <= 16'd0;
            r_cksum    <= 16'd0;
        end else begin
            r_start_d <= udp_tx_start;
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_dst_ip   <= udp_tx_dst_ip_addr;
                        r_dst_port <= udp_tx_dst_port;
                        r_src_port <= udp_tx_src_port;
                        r_len      <= udp_tx_data_length;
                        r_ip_len   <= udp_tx_data_length + 16'd8;
                        r_cksum    <= udp_tx_checksum;
                        r_count    <= 16'd0;
                        r_mismatch <= 1'b0;
                        if (udp_tx_data_length > MAX_DATA_LENGTH) begin
                            r_result <= UDPTX_RESULT_ERR;
                        end else begin
                            r_result <= UDPTX_RESULT_SENDING;
                            r_state  <= (ip_tx_result == IPTX_RESULT_SENDING) ?
                                        S_WAIT_IP : S_SEND_HDR;
                        end
                    end
                end
                S_WAIT_IP: begin
                    if (ip_tx_result != IPTX_RESULT_SENDING) begin
                        r_state <= S_SEND_HDR;
                    end
                end
                S_SEND_HDR: begin
                    if (ip_tx_result == IPTX_RESULT_ERR) begin
                        r_state  <= S_IDLE;
                        r_result <= UDPTX_RESULT_ERR;
                    end else if (w_xfer) begin
                        if (w_hdr_done) begin
                            r_count <= 16'd0;
                            if (r_len == 16'd0) begin
                                r_state  <= S_IDLE;
                                r_result <= UDPTX_RESULT_SENT;
                            end else begin
                                r_state <= S_SEND_DATA;
                            end
                        end else begin
                            r_count <= r_count + 16'd1;
                        end
                    end
                end
                default: begin
                    // The frame always ends on the byte count; user last only flags errors.
                    if (ip_tx_result == IPTX_RESULT_ERR) begin
                        r_state  <= S_IDLE;
                        r_result <= UDPTX_RESULT_ERR;
                    end else if (w_xfer) begin
                        r_mismatch <= r_mismatch || w_bad_last;
                        if (w_last) begin
                            r_state  <= S_IDLE;
                            r_result <= (r_mismatch || w_bad_last) ?
                                        UDPTX_RESULT_ERR : UDPTX_RESULT_SENT;
                        end else begin
                            r_count <= r_count + 16'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign udp_tx_data_out_ready = w_uready;
    assign udp_tx_result         = r_result;
    assign ip_tx_start           = w_ip_start;
    assign ip_tx_protocol        = UDP_PROTOCOL;
    assign ip_tx_data_length     = r_ip_len;
    assign ip_tx_dst_ip_addr     = r_dst_ip;
    assign ip_tx_data_out_valid  = w_valid;
    assign ip_tx_data_out_last   = w_last;
    assign ip_tx_data_out        = w_data;

endmodule

`default_nettype wire
